led_rx_decoder: RTL and testbench

Receiver end of the LED serial link driven by the LED send path (cko/sdo pair). It oversamples the incoming serial clock and data on a single fast system clock and deserialises MSB-first 24-bit words of the form R[3:0],4'hF,G[3:0],4'hF,B[3:0],4'hF. Each word is compressed back to a 12-bit RGB value and delivered on a valid/ready interface. Frames are delimited by link idle time; received word count is checked against the expected zone frame length. Used as the loopback checker / strip-side model.

---
 rtl/led_rx_decoder.sv | 166 ++++++++++++++++
 tb/tb_led_rx_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_rx_decoder.sv
// Oversampling receiver for the LED cki/sdi link: rebuilds MSB-first 24-bit words,
// compresses them to 12-bit RGB on a valid/ready port and checks frame length at idle.
module led_rx_decoder #(
    parameter int FRAME_WORDS  = 35,
    parameter int IDLE_TIMEOUT = 64,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_en,
    input  logic        cki,
    input  logic        sdi,
    output logic [11:0] word_data,
    output logic        word_fmt_err,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [5:0]  frame_cnt,
    output logic        overrun,
    input  logic        clr_status
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic [11:0] compress(input logic [23:0] w);
        return {w[23:20], w[15:12], w[7:4]};
    endfunction

    function automatic logic fmt_bad(input logic [23:0] w);
        return (w[19:16] != 4'hF) || (w[11:8] != 4'hF) || (w[3:0] != 4'hF);
    endfunction

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] cki_sync, sdi_sync;
    logic                   cki_prev;
    logic                   cki_s, sdi_s, cki_rise;
    logic [23:0]            shreg, shift_next;
    logic [4:0]             bit_cnt;
    logic [IW-1:0]          idle_cnt;
    logic [5:0]             word_cnt;
    logic                   frame_bad;
    logic                   start, abort, timeout, shift_en;
    logic                   word_done, pop, load, drop;

    // Both lines go through identical depth so sdi stays aligned with its cki edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cki_sync <= '0;
            sdi_sync <= '0;
            cki_prev <= 1'b0;
        end else begin
            cki_sync <= {cki_sync[SYNC_STAGES-2:0], cki};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cki_prev <= cki_sync[SYNC_STAGES-1];
        end
    end

    assign cki_s      = cki_sync[SYNC_STAGES-1];
    assign sdi_s      = sdi_sync[SYNC_STAGES-1];
    assign cki_rise   = cki_s & ~cki_prev;
    assign shift_next = {shreg[22:0], sdi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort      = 1'b0;
        timeout    = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_en && cki_rise) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!rx_en) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (cki_rise) begin
                    shift_en = 1'b1;
                end else if (idle_cnt == IW'(IDLE_TIMEOUT)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign word_done = shift_en && (bit_cnt == 5'd23);
    assign pop       = word_valid & word_ready;
    assign load      = word_done & (~word_valid | word_ready);
    assign drop      = word_done & ~load;

    // Deserialiser and per-frame accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            word_cnt  <= '0;
            frame_bad <= 1'b0;
        end else if (start) begin
            shreg     <= {23'd0, sdi_s};
            bit_cnt   <= 5'd1;
            idle_cnt  <= '0;
            word_cnt  <= '0;
            frame_bad <= 1'b0;
        end else if (shift_en) begin
            shreg    <= shift_next;
            bit_cnt  <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
            idle_cnt <= '0;
            if (word_done) begin
                if (word_cnt != 6'd63) word_cnt <= word_cnt + 6'd1;
                if (drop || fmt_bad(shift_next)) frame_bad <= 1'b1;
            end
        end else if (state == SHIFT && idle_cnt != IW'(IDLE_TIMEOUT)) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // Single-entry holding register; a pop in the completion cycle makes room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_data    <= '0;
            word_fmt_err <= 1'b0;
            word_valid   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load) begin
                word_data    <= compress(shift_next);
                word_fmt_err <= fmt_bad(shift_next);
                word_valid   <= 1'b1;
            end else if (pop) begin
                word_valid <= 1'b0;
            end
            if (clr_status) overrun <= 1'b0;
            if (drop)       overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= timeout | abort;
            if (timeout | abort) begin
                frame_cnt <= word_cnt;
                frame_ok  <= timeout && (word_cnt == 6'(FRAME_WORDS)) &&
                             (bit_cnt == 5'd0) && !frame_bad;
            end
        end
    end

endmodule

// File: tb/tb_led_rx_decoder.sv
// Randomised bench for led_rx_decoder: stimulus pushes expected words/frames into queues,
// a negedge monitor pops and compares whenever the DUT hands over a word or ends a frame.
module tb_led_rx_decoder;

    localparam int FRAME_WORDS  = 35;
    localparam int IDLE_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst, rx_en, cki, sdi, clr_status;
    logic        ready_force, rand_mode, rand_bit;
    logic        word_ready;
    logic [11:0] word_data;
    logic        word_fmt_err, word_valid, frame_done, frame_ok, overrun;
    logic [5:0]  frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] exp_words[$];
    int          exp_cnt[$];
    bit          exp_ok[$];

    logic        prev_v, prev_r;
    logic [12:0] prev_d;

    assign word_ready = rand_mode ? rand_bit : ready_force;

    always #5 clk = ~clk;

    led_rx_decoder #(.FRAME_WORDS(FRAME_WORDS), .IDLE_TIMEOUT(IDLE_TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .cki(cki), .sdi(sdi),
        .word_data(word_data), .word_fmt_err(word_fmt_err), .word_valid(word_valid),
        .word_ready(word_ready), .frame_done(frame_done), .frame_ok(frame_ok),
        .frame_cnt(frame_cnt), .overrun(overrun), .clr_status(clr_status)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] make_word(input logic [11:0] rgb, input logic [11:0] fill);
        return {rgb[11:8], fill[11:8], rgb[7:4], fill[7:4], rgb[3:0], fill[3:0]};
    endfunction

    task automatic push_word(input logic [11:0] rgb, input logic [11:0] fill);
        exp_words.push_back({rgb, fill != 12'hFFF});
    endtask

    // 3 clk low, 4 clk high; optional one-cycle ready pulse lands on the completion cycle
    task automatic send_bit(input logic b, input bit pulse);
        cki = 1'b0;
        sdi = b;
        repeat (3) tick();
        cki = 1'b1;
        tick();
        tick();
        if (pulse) ready_force = 1'b1;
        tick();
        if (pulse) ready_force = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [23:0] w, input bit pulse_last);
        for (int i = 23; i >= 0; i--) send_bit(w[i], pulse_last && (i == 0));
    endtask

    task automatic idle_gap();
        repeat (IDLE_TIMEOUT + 16) tick();
    endtask

    task automatic drain();
        rand_mode   = 1'b0;
        ready_force = 1'b1;
        repeat (4) tick();
    endtask

    always @(posedge clk) begin
        #1;
        rand_bit = ($urandom % 4) != 0;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
            prev_d = '0;
        end else begin
            if (prev_v && !prev_r && word_valid)
                check("held_word_stable", {word_data, word_fmt_err}, prev_d);
            if (word_valid && word_ready) begin
                if (exp_words.size() == 0) check("unexpected_word", 1, 0);
                else begin
                    logic [12:0] e;
                    e = exp_words.pop_front();
                    check("word_data", word_data, e[12:1]);
                    check("word_fmt_err", word_fmt_err, e[0]);
                end
            end
            if (frame_done) begin
                if (exp_cnt.size() == 0) check("unexpected_frame_done", 1, 0);
                else begin
                    check("frame_cnt", frame_cnt, exp_cnt.pop_front());
                    check("frame_ok", frame_ok, exp_ok.pop_front());
                end
            end
            prev_v = word_valid;
            prev_r = word_ready;
            prev_d = {word_data, word_fmt_err};
        end
    end

    initial begin
        logic [11:0] rgb, fill;
        int          n, part;
        bit          bad;

        rst = 1'b1; rx_en = 1'b1; cki = 1'b0; sdi = 1'b0; clr_status = 1'b0;
        ready_force = 1'b1; rand_mode = 1'b0;
        repeat (4) tick();
        check("rst_word_valid", word_valid, 0);
        check("rst_word_data", word_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        repeat (4) tick();

        // Full frame, word k carries RGB=k
        for (int k = 0; k < FRAME_WORDS; k++) begin
            push_word(12'(k), 12'hFFF);
            send_word(make_word(12'(k), 12'hFFF), 1'b0);
        end
        exp_cnt.push_back(FRAME_WORDS); exp_ok.push_back(1'b1);
        idle_gap();

        // Known filler-good and filler-bad words inside a full-length frame
        push_word(12'hA53, 12'hFFF); send_word(24'hAF5F3F, 1'b0);
        push_word(12'hA53, 12'hFEF); send_word(24'hAF5E3F, 1'b0);
        for (int k = 2; k < FRAME_WORDS; k++) begin
            rgb = 12'($urandom);
            push_word(rgb, 12'hFFF);
            send_word(make_word(rgb, 12'hFFF), 1'b0);
        end
        exp_cnt.push_back(FRAME_WORDS); exp_ok.push_back(1'b0);
        idle_gap();

        // 34 words plus 10 stray bits
        for (int k = 0; k < 34; k++) begin
            rgb = 12'($urandom);
            push_word(rgb, 12'hFFF);
            send_word(make_word(rgb, 12'hFFF), 1'b0);
        end
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
        exp_cnt.push_back(34); exp_ok.push_back(1'b0);
        idle_gap();

        // Randomised frames with random back-pressure
        for (int f = 0; f < 3; f++) begin
            n    = 33 + int'($urandom % 4);
            part = (($urandom % 3) == 0) ? 1 + int'($urandom % 23) : 0;
            bad  = 1'b0;
            rand_mode = 1'b1;
            for (int k = 0; k < n; k++) begin
                rgb  = 12'($urandom);
                fill = (($urandom % 8) == 0) ? 12'($urandom) : 12'hFFF;
                if (fill != 12'hFFF) bad = 1'b1;
                push_word(rgb, fill);
                send_word(make_word(rgb, fill), 1'b0);
            end
            for (int i = 0; i < part; i++) send_bit(1'($urandom), 1'b0);
            exp_cnt.push_back(n);
            exp_ok.push_back((n == FRAME_WORDS) && !bad && (part == 0));
            idle_gap();
            check("no_overrun_random", overrun, 0);
        end
        drain();

        // Back-pressure across two completions: second word dropped
        ready_force = 1'b0;
        push_word(12'h123, 12'hFFF); send_word(make_word(12'h123, 12'hFFF), 1'b0);
        send_word(make_word(12'h456, 12'hFFF), 1'b0);
        check("overrun_set", overrun, 1);
        ready_force = 1'b1;
        push_word(12'h789, 12'hFFF); send_word(make_word(12'h789, 12'hFFF), 1'b0);
        exp_cnt.push_back(3); exp_ok.push_back(1'b0);
        idle_gap();
        check("overrun_sticky", overrun, 1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        tick();
        check("overrun_cleared", overrun, 0);

        // Pop in the same cycle as the next word completes
        ready_force = 1'b0;
        push_word(12'hABC, 12'hFFF); send_word(make_word(12'hABC, 12'hFFF), 1'b0);
        push_word(12'hDEF, 12'hFFF); send_word(make_word(12'hDEF, 12'hFFF), 1'b1);
        check("pop_collide_valid", word_valid, 1);
        check("pop_collide_data", word_data, 12'hDEF);
        check("pop_collide_overrun", overrun, 0);
        ready_force = 1'b1;
        exp_cnt.push_back(2); exp_ok.push_back(1'b0);
        idle_gap();

        // rx_en drop aborts the frame
        for (int k = 0; k < 5; k++) begin
            rgb = 12'($urandom);
            push_word(rgb, 12'hFFF);
            send_word(make_word(rgb, 12'hFFF), 1'b0);
        end
        exp_cnt.push_back(5); exp_ok.push_back(1'b0);
        tick();
        rx_en = 1'b0;
        repeat (8) tick();
        rx_en = 1'b1;
        repeat (4) tick();

        // Reset in the middle of word 3
        for (int k = 0; k < 2; k++) begin
            rgb = 12'($urandom);
            push_word(rgb, 12'hFFF);
            send_word(make_word(rgb, 12'hFFF), 1'b0);
        end
        for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1'b0);
        cki = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("midrst_word_valid", word_valid, 0);
        check("midrst_word_data", word_data, 0);
        check("midrst_fmt_err", word_fmt_err, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_frame_ok", frame_ok, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_overrun", overrun, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < FRAME_WORDS; k++) begin
            rgb = 12'($urandom);
            push_word(rgb, 12'hFFF);
            send_word(make_word(rgb, 12'hFFF), 1'b0);
        end
        exp_cnt.push_back(FRAME_WORDS); exp_ok.push_back(1'b1);
        idle_gap();

        for (int i = 0; i < 500 && (exp_words.size() != 0 || exp_cnt.size() != 0); i++) tick();
        check("words_outstanding", exp_words.size(), 0);
        check("frames_outstanding", exp_cnt.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
